hamming_minmax_engine: RTL and testbench



---
 rtl/ham_pkg.sv | 34 +++
 rtl/hamming_dist16.sv | 15 +
 rtl/hamming_minmax_engine.sv | 171 +++++++++++++++++
 tb/tb_hamming_minmax_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared types and constants for the Hamming min/max engine.
// Holds the state encoding, operand geometry and the popcount helper.
package ham_pkg;

    localparam int NUM_WORDS = 32;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int DIST_W    = $clog2(WORD_W + 1);
    localparam int NUM_PAIRS = NUM_WORDS * (NUM_WORDS - 1) / 2;

    localparam logic [ADDR_W-1:0] MIN_ADDR = 8'd64;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 8'd65;
    localparam logic [DIST_W-1:0] MIN_INIT = 5'd16;
    localparam logic [DIST_W-1:0] MAX_INIT = 5'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CMP    = 3'd2,
        WR_MIN = 3'd3,
        WR_MAX = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [DIST_W-1:0] popcount16(input logic [WORD_W-1:0] v);
        logic [DIST_W-1:0] c;
        c = 5'd0;
        for (int i = 0; i < WORD_W; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/hamming_dist16.sv
// Combinational Hamming distance between two operands (XOR then popcount).
module hamming_dist16
    import ham_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic [DIST_W-1:0] o_dist
);

    // Distance is the number of differing bit positions.
    always_comb begin
        o_dist = popcount16(i_a ^ i_b);
    end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Loads 32 big-endian 16-bit words from data memory, scans all pairwise Hamming
// distances and writes the minimum and maximum back to bytes 64 and 65.
module hamming_minmax_engine
    import ham_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    state_t              r_state;
    logic                r_armed;
    logic [DIST_W-1:0]   r_min;
    logic [DIST_W-1:0]   r_max;
    logic [6:0]          r_cnt;
    logic [4:0]          r_j;
    logic [4:0]          r_k;
    logic                r_done;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wr_data;
    logic [WORD_W-1:0]   r_cache [NUM_WORDS];

    logic [DIST_W-1:0]   w_dist;
    logic [DIST_W-1:0]   w_min_nxt;
    logic [DIST_W-1:0]   w_max_nxt;
    logic [5:0]          w_cap_idx;

    hamming_dist16 u_dist (
        .i_a    (r_cache[r_j]),
        .i_b    (r_cache[r_k]),
        .o_dist (w_dist)
    );

    // Strict-compare running extremes for the current pair.
    always_comb begin
        w_min_nxt = r_min;
        w_max_nxt = r_max;
        w_cap_idx = 6'(r_cnt - 7'd1);
        if (r_state == CMP) begin
            if (w_dist < r_min) begin
                w_min_nxt = w_dist;
            end else begin
                w_min_nxt = r_min;
            end
            if (w_dist > r_max) begin
                w_max_nxt = w_dist;
            end else begin
                w_max_nxt = r_max;
            end
        end else begin
            w_min_nxt = r_min;
            w_max_nxt = r_max;
        end
    end

    // Operand capture: the byte for address n arrives while r_cnt == n+1.
    always_ff @(posedge clk) begin
        if (r_state == LOAD && r_cnt != 7'd0) begin
            if (w_cap_idx[0]) begin
                r_cache[w_cap_idx[5:1]][7:0]  <= mem_rd_data;
            end else begin
                r_cache[w_cap_idx[5:1]][15:8] <= mem_rd_data;
            end
        end
    end

    // Control FSM with registered memory-side and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_min     <= MIN_INIT;
            r_max     <= MAX_INIT;
            r_cnt     <= 7'd0;
            r_j       <= 5'd0;
            r_k       <= 5'd0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= 8'd0;
            r_wr_data <= 8'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= LOAD;
                        r_armed <= 1'b0;
                        r_min   <= MIN_INIT;
                        r_max   <= MAX_INIT;
                        r_cnt   <= 7'd0;
                        r_j     <= 5'd0;
                        r_k     <= 5'd0;
                        r_addr  <= 8'd0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    if (r_cnt == 7'd64) begin
                        r_state <= CMP;
                        r_cnt   <= 7'd0;
                        r_j     <= 5'd0;
                        r_k     <= 5'd1;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                        if (r_cnt < 7'd63) begin
                            r_addr <= ADDR_W'(r_cnt + 7'd1);
                        end else begin
                            r_addr <= r_addr;
                        end
                    end
                end
                CMP: begin
                    r_min <= w_min_nxt;
                    r_max <= w_max_nxt;
                    if (r_j == 5'd30 && r_k == 5'd31) begin
                        r_state   <= WR_MIN;
                        r_addr    <= MIN_ADDR;
                        r_wr_data <= {3'b000, w_min_nxt};
                        r_wr_en   <= 1'b1;
                    end else if (r_k == 5'd31) begin
                        r_j <= r_j + 5'd1;
                        r_k <= r_j + 5'd2;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end
                WR_MIN: begin
                    r_state   <= WR_MAX;
                    r_addr    <= MAX_ADDR;
                    r_wr_data <= {3'b000, r_max};
                    r_wr_en   <= 1'b1;
                end
                WR_MAX: begin
                    r_state   <= DONE;
                    r_done    <= 1'b1;
                    r_addr    <= 8'd0;
                    r_wr_data <= 8'd0;
                end
                DONE: begin
                    if (start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_armed <= 1'b1;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign mem_addr    = r_addr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_data = r_wr_data;

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Self-checking bench: byte memory model, scoreboard of expected Min/Max per run.
module tb_hamming_minmax_engine;
    import ham_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    logic [7:0]        data_bytes [64];
    logic [7:0]        res_min;
    logic [7:0]        res_max;
    logic              preset_req;
    int                wr_cnt;
    int                bad_wr_cnt;

    logic [WORD_W-1:0] hd_a;
    logic [WORD_W-1:0] hd_b;
    logic [DIST_W-1:0] hd_dist;

    int n_checks;
    int n_errors;

    typedef struct {
        int mn;
        int mx;
    } exp_t;
    exp_t sb_q[$];

    hamming_minmax_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    hamming_dist16 u_hd (
        .i_a    (hd_a),
        .i_b    (hd_b),
        .o_dist (hd_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, result bytes 64/65 writable, others flagged.
    always @(posedge clk) begin
        if (mem_addr < 8'd64)       mem_rd_data <= data_bytes[mem_addr[5:0]];
        else if (mem_addr == 8'd64) mem_rd_data <= res_min;
        else if (mem_addr == 8'd65) mem_rd_data <= res_max;
        else                        mem_rd_data <= 8'd0;
        if (preset_req) begin
            res_min <= 8'd16;
            res_max <= 8'd0;
        end else if (mem_wr_en) begin
            if (mem_addr == 8'd64)      res_min <= mem_wr_data;
            else if (mem_addr == 8'd65) res_max <= mem_wr_data;
            else                        bad_wr_cnt <= bad_wr_cnt + 1;
        end
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input int i);
        return {data_bytes[2*i], data_bytes[2*i+1]};
    endfunction

    task automatic push_expected();
        exp_t e;
        int d;
        e.mn = 16;
        e.mx = 0;
        for (int j = 0; j < 31; j++) begin
            for (int k = j + 1; k < 32; k++) begin
                d = $countones(word_at(j) ^ word_at(k));
                if (d < e.mn) e.mn = d;
                if (d > e.mx) e.mx = d;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic set_words(input int mode);
        logic [15:0] w;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       w = 16'h0000;
                1:       w = 16'(i);
                2:       w = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
                3:       w = (i == 1) ? 16'h00FF : 16'hFF00;
                default: w = 16'($urandom);
            endcase
            data_bytes[2*i]   = w[15:8];
            data_bytes[2*i+1] = w[7:0];
        end
    endtask

    // Return DUT to IDLE (armed) by presenting start high for one edge.
    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_and_check(input string tag);
        exp_t e;
        int lat;
        int w0;
        push_expected();
        @(negedge clk);
        w0 = wr_cnt;
        start = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (done === 1'b1) break;
        end
        e = sb_q.pop_front();
        check_eq({tag, "_latency"}, lat, 563);
        check_eq({tag, "_min"}, {24'd0, res_min}, e.mn);
        check_eq({tag, "_max"}, {24'd0, res_max}, e.mx);
        check_eq({tag, "_strobes"}, wr_cnt - w0, 2);
    endtask

    initial begin
        int bad;
        int w0;
        n_checks   = 0;
        n_errors   = 0;
        wr_cnt     = 0;
        bad_wr_cnt = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        preset_req = 1'b1;
        hd_a       = 16'h0000;
        hd_b       = 16'h0000;
        set_words(0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_wr_en", {31'd0, mem_wr_en}, 0);
        check_eq("rst_addr", {24'd0, mem_addr}, 0);
        check_eq("rst_wr_data", {24'd0, mem_wr_data}, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        preset_req = 1'b0;

        for (int t = 0; t < 4; t++) begin
            hd_a = (t == 0) ? 16'hFFFF : 16'($urandom);
            hd_b = (t == 0) ? 16'h0000 : 16'($urandom);
            #1;
            check_eq("dist16", {27'd0, hd_dist}, $countones(hd_a ^ hd_b));
        end

        // start low straight out of reset must not launch
        bad = 0;
        w0  = wr_cnt;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) bad++;
        end
        check_eq("no_false_launch", bad, 0);
        check_eq("no_false_strobes", wr_cnt - w0, 0);

        arm();
        run_and_check("zeros");

        set_words(1);
        arm();
        run_and_check("ramp");

        repeat (1000) @(negedge clk);
        check_eq("done_held", {31'd0, done}, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("done_falls", {31'd0, done}, 0);

        set_words(2);
        arm();
        run_and_check("alt");

        set_words(3);
        arm();
        run_and_check("byteorder");

        // reset pulse in the middle of the compare phase
        set_words(4);
        arm();
        preset_req = 1'b1;
        @(negedge clk);
        preset_req = 1'b0;
        w0 = wr_cnt;
        start = 1'b0;
        repeat (265) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (700) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) bad++;
        end
        check_eq("abort_done_low", bad, 0);
        check_eq("abort_min_kept", {24'd0, res_min}, 16);
        check_eq("abort_max_kept", {24'd0, res_max}, 0);
        check_eq("abort_no_strobes", wr_cnt - w0, 0);
        arm();
        run_and_check("rerun");

        for (int r = 0; r < 10; r++) begin
            set_words(4);
            arm();
            run_and_check("random");
        end

        check_eq("no_low_writes", bad_wr_cnt, 0);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
